vending_machine_param: RTL and testbench

Parametrised vending-machine controller: configurable coin denominations and item count, with per-item stock tracking. Adds features beyond the fixed 3-coin/4-item machine: greedy change return, an inactivity timeout, rejection of coins that would overflow the balance, and restock. It is a standalone top-level FSM, driven directly by coin, select and return inputs. It replaces the fixed-configuration vending machine in the lab hierarchy.

---
 rtl/vm_pkg.sv | 9 +
 rtl/vm_change_picker.sv | 21 ++
 rtl/vending_machine_param.sv | 112 +++++++++++
 tb/tb_vending_machine_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: state encoding, default coin/price tables and the widened-arithmetic width helper for vending_machine_param
package vm_pkg;
    typedef enum logic {VM_IDLE, VM_RETURN} vm_state_t;
    localparam logic [47:0] VM_COIN_VALS = {16'd1000, 16'd500, 16'd100};
    localparam logic [63:0] VM_ITEM_PRICES = {16'd2000, 16'd1000, 16'd500, 16'd400};
    function automatic int vm_ext_w(input int bal_w);
        return bal_w + 2;
    endfunction
endpackage

// File: rtl/vm_change_picker.sv
// vm_change_picker: balance, coin_vals -> coin (one-hot of the largest coin not above balance), value (its value, 0 if none fits)
module vm_change_picker #(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic [W-1:0]   balance,
    input  logic [N*W-1:0] coin_vals,
    output logic [N-1:0]   coin,
    output logic [W-1:0]   value
);
    always_comb begin
        coin = '0;
        value = '0;
        for (int k = 0; k < N; k++)
            if (coin_vals[k*W +: W] <= balance) begin
                coin = '0;
                coin[k] = 1'b1;
                value = coin_vals[k*W +: W];
            end
    end
endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param: coin/select/return/restock in; available, dispense, change, reject pulses and balance out
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int NUM_COINS = 3,
    parameter int NUM_ITEMS = 4,
    parameter int BAL_W = 16,
    parameter logic [NUM_COINS*BAL_W-1:0] COIN_VALS = VM_COIN_VALS,
    parameter logic [NUM_ITEMS*BAL_W-1:0] ITEM_PRICES = VM_ITEM_PRICES,
    parameter int STOCK_W = 4,
    parameter int INIT_STOCK = 8,
    parameter int RETURN_WAIT = 100
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_COINS-1:0] i_input_coin,
    input  logic [NUM_ITEMS-1:0] i_select_item,
    input  logic                 i_trigger_return,
    input  logic                 i_restock,
    output logic [NUM_ITEMS-1:0] o_available_item,
    output logic [NUM_ITEMS-1:0] o_output_item,
    output logic [NUM_COINS-1:0] o_return_coin,
    output logic                 o_coin_reject,
    output logic [BAL_W-1:0]     o_balance
);
    localparam int XW = vm_ext_w(BAL_W);
    localparam int CW = $clog2(RETURN_WAIT) + 1;
    localparam logic [XW-1:0] MAX_BAL = {2'b00, {BAL_W{1'b1}}};
    localparam logic [BAL_W-1:0] COIN0 = COIN_VALS[BAL_W-1:0];
    vm_state_t state, state_n;
    logic [BAL_W-1:0] balance, bal_n, price_sel, pick_val, rest;
    logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock;
    logic [CW-1:0] cnt, cnt_n;
    logic [NUM_COINS-1:0] prev_coin, coin_ev, pick_coin, ret_n;
    logic [NUM_ITEMS-1:0] prev_sel, sel_ev, sel_hit, sel_oh, item_n;
    logic [XW-1:0] coin_sum, next_bal;
    logic over, rej_n;
    vm_change_picker #(.N(NUM_COINS), .W(BAL_W)) u_pick (
        .balance(balance),
        .coin_vals(COIN_VALS),
        .coin(pick_coin),
        .value(pick_val)
    );
    assign coin_ev = i_input_coin & ~prev_coin;
    assign sel_ev = i_select_item & ~prev_sel;
    assign sel_hit = sel_ev & o_available_item;
    assign sel_oh = sel_hit & -sel_hit;
    assign o_balance = balance;
    always_comb begin
        o_available_item = '0;
        price_sel = '0;
        coin_sum = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            o_available_item[i] = balance >= ITEM_PRICES[i*BAL_W +: BAL_W] && stock[i] != '0;
            price_sel = sel_oh[i] ? ITEM_PRICES[i*BAL_W +: BAL_W] : price_sel;
        end
        for (int k = 0; k < NUM_COINS; k++)
            coin_sum = coin_sum + (coin_ev[k] ? {2'b00, COIN_VALS[k*BAL_W +: BAL_W]} : '0);
        next_bal = {2'b00, balance} - {2'b00, price_sel} + coin_sum;
        over = next_bal > MAX_BAL;
        rest = balance - pick_val;
    end
    always_comb begin
        state_n = state;
        bal_n = balance;
        cnt_n = '0;
        item_n = '0;
        ret_n = '0;
        rej_n = |coin_ev;
        if (state == VM_RETURN) begin
            ret_n = pick_coin;
            bal_n = rest < COIN0 ? '0 : rest;
            state_n = rest < COIN0 ? VM_IDLE : VM_RETURN;
        end else if ((i_trigger_return || cnt == CW'(RETURN_WAIT - 1)) && balance != '0) begin
            state_n = VM_RETURN;
        end else begin
            item_n = sel_oh;
            rej_n = over && |coin_ev;
            bal_n = over ? balance - price_sel : next_bal[BAL_W-1:0];
            cnt_n = (|coin_ev || |sel_ev || balance == '0) ? '0 : cnt + CW'(1);
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= VM_IDLE;
            balance <= '0;
            cnt <= '0;
            prev_coin <= '0;
            prev_sel <= '0;
            o_output_item <= '0;
            o_return_coin <= '0;
            o_coin_reject <= 1'b0;
        end else begin
            state <= state_n;
            balance <= bal_n;
            cnt <= cnt_n;
            prev_coin <= i_input_coin;
            prev_sel <= i_select_item;
            o_output_item <= item_n;
            o_return_coin <= ret_n;
            o_coin_reject <= rej_n;
        end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < NUM_ITEMS; i++)
                stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++)
                if (i_restock) stock[i] <= STOCK_W'(INIT_STOCK);
                else if (item_n[i]) stock[i] <= stock[i] - STOCK_W'(1);
        end
endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param: directed stimulus with a cycle model and literal checkpoints for vending_machine_param
module tb_vending_machine_param;
    localparam int BW = 12;
    localparam int IS = 2;
    localparam int RW = 10;
    localparam int MAXB = 4095;
    logic clk = 0;
    logic reset_n = 0;
    logic [2:0] coin_in = '0;
    logic [3:0] sel_in = '0;
    logic trig = 0;
    logic restock = 0;
    logic [3:0] avail, out_item;
    logic [2:0] ret_coin;
    logic rej;
    logic [BW-1:0] bal;
    int checks = 0;
    int errors = 0;
    int cv[3] = '{100, 500, 1000};
    int pr[4] = '{400, 500, 1000, 2000};
    int m_bal, m_cnt;
    int m_st[4];
    bit m_ret;
    logic [3:0] m_out, m_ps, ea;
    logic [2:0] m_rc, m_pc;
    logic m_rej;
    always #5 clk = ~clk;
    vending_machine_param #(
        .NUM_COINS(3), .NUM_ITEMS(4), .BAL_W(BW),
        .COIN_VALS({12'd1000, 12'd500, 12'd100}),
        .ITEM_PRICES({12'd2000, 12'd1000, 12'd500, 12'd400}),
        .STOCK_W(4), .INIT_STOCK(IS), .RETURN_WAIT(RW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_input_coin(coin_in), .i_select_item(sel_in),
        .i_trigger_return(trig), .i_restock(restock), .o_available_item(avail),
        .o_output_item(out_item), .o_return_coin(ret_coin), .o_coin_reject(rej), .o_balance(bal)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_step();
        logic [2:0] ce;
        logic [3:0] se;
        int sum, s, nb, k;
        ce = coin_in & ~m_pc;
        se = sel_in & ~m_ps;
        m_out = '0;
        m_rc = '0;
        m_rej = (ce != 0);
        if (m_ret) begin
            k = 0;
            for (int j = 0; j < 3; j++) if (cv[j] <= m_bal) k = j;
            m_rc = 3'(1 << k);
            m_bal -= cv[k];
            if (m_bal < cv[0]) begin
                m_bal = 0;
                m_ret = 0;
            end
            m_cnt = 0;
        end else if ((trig || m_cnt == RW - 1) && m_bal != 0) begin
            m_ret = 1;
            m_cnt = 0;
        end else begin
            sum = 0;
            for (int j = 0; j < 3; j++) if (ce[j]) sum += cv[j];
            s = -1;
            for (int i = 3; i >= 0; i--) if (se[i] && m_bal >= pr[i] && m_st[i] > 0) s = i;
            nb = m_bal + sum;
            if (s >= 0) begin
                nb -= pr[s];
                m_out = 4'(1 << s);
                m_st[s]--;
            end
            m_rej = 0;
            if (nb > MAXB) begin
                m_rej = 1;
                nb -= sum;
            end
            m_cnt = (ce != 0 || se != 0 || m_bal == 0) ? 0 : m_cnt + 1;
            m_bal = nb;
        end
        if (restock) for (int i = 0; i < 4; i++) m_st[i] = IS;
        m_pc = coin_in;
        m_ps = sel_in;
    endtask
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_bal = 0;
            m_cnt = 0;
            m_ret = 0;
            m_out = '0;
            m_rc = '0;
            m_rej = 0;
            m_pc = '0;
            m_ps = '0;
            for (int i = 0; i < 4; i++) m_st[i] = IS;
        end else model_step();
    end
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) ea[i] = (m_bal >= pr[i] && m_st[i] > 0);
        check("balance", 32'(bal), m_bal);
        check("available", 32'(avail), 32'(ea));
        check("output_item", 32'(out_item), 32'(m_out));
        check("return_coin", 32'(ret_coin), 32'(m_rc));
        check("coin_reject", 32'(rej), 32'(m_rej));
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic coin(input int k);
        coin_in[k] = 1'b1;
        tick();
        coin_in = '0;
        tick();
    endtask
    task automatic pick(input int i);
        sel_in[i] = 1'b1;
        tick();
        sel_in = '0;
        tick();
    endtask
    initial begin
        logic [2:0] er[6];
        int eb[6];
        int n;
        er = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001};
        eb = '{1400, 400, 300, 200, 100, 0};
        tick();
        tick();
        check("rst_balance", 32'(bal), 0);
        check("rst_avail", 32'(avail), 0);
        check("rst_item", 32'(out_item), 0);
        check("rst_ret", 32'(ret_coin), 0);
        check("rst_rej", 32'(rej), 0);
        reset_n = 1;
        tick();
        repeat (4) coin(0);
        check("bal_400", 32'(bal), 400);
        check("avail_400", 32'(avail), 4'b0001);
        coin(0);
        check("bal_500", 32'(bal), 500);
        check("avail_500", 32'(avail), 4'b0011);
        trig = 1;
        tick();
        trig = 0;
        check("ret_first_wait", 32'(ret_coin), 0);
        tick();
        check("ret_500", 32'(ret_coin), 3'b010);
        check("ret_500_bal", 32'(bal), 0);
        tick();
        check("ret_500_done", 32'(ret_coin), 0);
        repeat (3) coin(2);
        check("bal_3000", 32'(bal), 3000);
        sel_in = 4'b0001;
        tick();
        check("hold_pulse", 32'(out_item), 4'b0001);
        check("hold_bal", 32'(bal), 2600);
        tick();
        check("hold_no_repeat1", 32'(out_item), 0);
        tick();
        check("hold_no_repeat2", 32'(out_item), 0);
        sel_in = '0;
        tick();
        pick(0);
        check("second_bal", 32'(bal), 2200);
        check("sold_out_avail", 32'(avail), 4'b1110);
        sel_in = 4'b0001;
        tick();
        check("sold_out_item", 32'(out_item), 0);
        check("sold_out_bal", 32'(bal), 2200);
        sel_in = '0;
        restock = 1;
        tick();
        restock = 0;
        check("restock_avail", 32'(avail), 4'b1111);
        repeat (2) coin(0);
        check("bal_2400", 32'(bal), 2400);
        trig = 1;
        tick();
        trig = 0;
        check("ret2400_wait", 32'(ret_coin), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ret2400_coin", 32'(ret_coin), 32'(er[i]));
            check("ret2400_bal", 32'(bal), eb[i]);
        end
        tick();
        check("ret2400_idle", 32'(ret_coin), 0);
        coin(1);
        n = 0;
        while (n < 30 && ret_coin == '0) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 10);
        check("timeout_coin", 32'(ret_coin), 3'b010);
        check("timeout_bal", 32'(bal), 0);
        repeat (4) coin(2);
        check("bal_4000", 32'(bal), 4000);
        coin_in = 3'b001;
        tick();
        check("ovf_rej", 32'(rej), 1);
        check("ovf_bal", 32'(bal), 4000);
        coin_in = '0;
        tick();
        check("ovf_rej_end", 32'(rej), 0);
        trig = 1;
        tick();
        trig = 0;
        coin_in = 3'b001;
        tick();
        check("ret_rej", 32'(rej), 1);
        check("ret_rej_coin", 32'(ret_coin), 3'b100);
        check("ret_rej_bal", 32'(bal), 3000);
        coin_in = '0;
        n = 0;
        while (n < 20 && bal != '0) begin
            tick();
            n++;
        end
        check("ret4000_drain", 32'(bal), 0);
        tick();
        trig = 1;
        coin_in = 3'b001;
        tick();
        trig = 0;
        coin_in = '0;
        check("trig_zero_bal", 32'(bal), 100);
        tick();
        check("trig_zero_noret", 32'(ret_coin), 0);
        trig = 1;
        coin_in = 3'b010;
        tick();
        trig = 0;
        coin_in = '0;
        check("trig_prio_rej", 32'(rej), 1);
        check("trig_prio_bal", 32'(bal), 100);
        tick();
        check("trig_prio_ret", 32'(ret_coin), 3'b001);
        check("trig_prio_done", 32'(bal), 0);
        repeat (2) coin(2);
        trig = 1;
        tick();
        trig = 0;
        tick();
        check("abort_pulse", 32'(ret_coin), 3'b100);
        reset_n = 0;
        #1;
        check("abort_bal", 32'(bal), 0);
        check("abort_ret", 32'(ret_coin), 0);
        tick();
        reset_n = 1;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
